// File: rtl/dec8b10b_pkg.sv
// Shared definitions for the 8b/10b receive-side disparity checker.
// Holds the running-disparity encoding, the sub-block weight classes, the
// special sub-block patterns, and helpers that split a symbol into its
// abcdei / fghj sub-blocks.
package dec8b10b_pkg;

    localparam int unsigned SYM_W  = 10;
    localparam int unsigned SIX_W  = 6;
    localparam int unsigned FOUR_W = 4;
    localparam int unsigned BYTE_W = 8;

    localparam logic RD_NEG = 1'b0;
    localparam logic RD_POS = 1'b1;

    // 6b sub-blocks are written abcdei (a in the MSB); 4b sub-blocks are fghj
    localparam logic [SIX_W-1:0]  SIX_000111 = 6'b000111;
    localparam logic [SIX_W-1:0]  SIX_111000 = 6'b111000;
    localparam logic [SIX_W-1:0]  SIX_K28_N  = 6'b001111;
    localparam logic [SIX_W-1:0]  SIX_K28_P  = 6'b110000;
    localparam logic [FOUR_W-1:0] FOUR_0011  = 4'b0011;
    localparam logic [FOUR_W-1:0] FOUR_1100  = 4'b1100;
    localparam logic [FOUR_W-1:0] FOUR_A7_N  = 4'b1000;
    localparam logic [FOUR_W-1:0] FOUR_A7_P  = 4'b0111;
    localparam logic [FOUR_W-1:0] FOUR_P7_N  = 4'b1110;
    localparam logic [FOUR_W-1:0] FOUR_P7_P  = 4'b0001;

    typedef enum logic [1:0] {
        WC_NEG = 2'd0,
        WC_NEU = 2'd1,
        WC_POS = 2'd2,
        WC_BAD = 2'd3
    } wclass_e;

    // abcdei view of a symbol {j,h,g,f,i,e,d,c,b,a}
    function automatic logic [SIX_W-1:0] abcdei(input logic [SYM_W-1:0] s);
        abcdei = {s[0], s[1], s[2], s[3], s[4], s[5]};
    endfunction

    // fghj view of a symbol
    function automatic logic [FOUR_W-1:0] fghj(input logic [SYM_W-1:0] s);
        fghj = {s[6], s[7], s[8], s[9]};
    endfunction

    function automatic wclass_e class6(input logic [SIX_W-1:0] v);
        logic [2:0] n;
        n = '0;
        for (int i = 0; i < int'(SIX_W); i++) n = n + 3'(v[i]);
        case (n)
            3'd2:    class6 = WC_NEG;
            3'd3:    class6 = WC_NEU;
            3'd4:    class6 = WC_POS;
            default: class6 = WC_BAD;
        endcase
    endfunction

    function automatic wclass_e class4(input logic [FOUR_W-1:0] v);
        logic [2:0] n;
        n = '0;
        for (int i = 0; i < int'(FOUR_W); i++) n = n + 3'(v[i]);
        case (n)
            3'd1:    class4 = WC_NEG;
            3'd2:    class4 = WC_NEU;
            3'd3:    class4 = WC_POS;
            default: class4 = WC_BAD;
        endcase
    endfunction

endpackage

// File: rtl/dec_lut.sv
// Combinational 6b->5b and 4b->3b decode tables with control-character detect.
// Ports:
//   sym   - received symbol {j,h,g,f,i,e,d,c,b,a}
//   k28   - 6b sub-block is a K28 form (001111 / 110000)
//   edcba - decoded low five bits
//   hgf   - decoded high three bits
//   miss6 - abcdei not present in the 5b/6b table
//   miss4 - fghj not present in the 3b/4b table, or illegal for K28
//   kout  - symbol is a legal control character (before code-error masking)
module dec_lut
    import dec8b10b_pkg::*;
(
    input  logic [SYM_W-1:0] sym,
    input  logic             k28,
    output logic [4:0]       edcba,
    output logic [2:0]       hgf,
    output logic             miss6,
    output logic             miss4,
    output logic             kout
);

    logic [SIX_W-1:0]  six;
    logic [FOUR_W-1:0] four_raw;
    logic [FOUR_W-1:0] four;
    logic              kx7;

    // K28 after a 110000 sub-block carries the complemented 4b form
    always_comb begin
        six      = abcdei(sym);
        four_raw = fghj(sym);
        four     = (k28 && six == SIX_K28_P) ? ~four_raw : four_raw;
    end

    // 5b/6b table
    always_comb begin
        edcba = '0;
        miss6 = 1'b0;
        case (six)
            6'b100111, 6'b011000:            edcba = 5'd0;
            6'b011101, 6'b100010:            edcba = 5'd1;
            6'b101101, 6'b010010:            edcba = 5'd2;
            6'b110001:                       edcba = 5'd3;
            6'b110101, 6'b001010:            edcba = 5'd4;
            6'b101001:                       edcba = 5'd5;
            6'b011001:                       edcba = 5'd6;
            6'b111000, 6'b000111:            edcba = 5'd7;
            6'b111001, 6'b000110:            edcba = 5'd8;
            6'b100101:                       edcba = 5'd9;
            6'b010101:                       edcba = 5'd10;
            6'b110100:                       edcba = 5'd11;
            6'b001101:                       edcba = 5'd12;
            6'b101100:                       edcba = 5'd13;
            6'b011100:                       edcba = 5'd14;
            6'b010111, 6'b101000:            edcba = 5'd15;
            6'b011011, 6'b100100:            edcba = 5'd16;
            6'b100011:                       edcba = 5'd17;
            6'b010011:                       edcba = 5'd18;
            6'b110010:                       edcba = 5'd19;
            6'b001011:                       edcba = 5'd20;
            6'b101010:                       edcba = 5'd21;
            6'b011010:                       edcba = 5'd22;
            6'b111010, 6'b000101:            edcba = 5'd23;
            6'b110011, 6'b001100:            edcba = 5'd24;
            6'b100110:                       edcba = 5'd25;
            6'b010110:                       edcba = 5'd26;
            6'b110110, 6'b001001:            edcba = 5'd27;
            6'b001110, 6'b001111, 6'b110000: edcba = 5'd28;
            6'b101110, 6'b010001:            edcba = 5'd29;
            6'b011110, 6'b100001:            edcba = 5'd30;
            6'b101011, 6'b010100:            edcba = 5'd31;
            default:                         miss6 = 1'b1;
        endcase
    end

    // 3b/4b table; primary and alternate x.7 both map to 111
    always_comb begin
        hgf   = '0;
        miss4 = 1'b0;
        case (four)
            4'b1011, 4'b0100:                   hgf = 3'd0;
            4'b1001:                            hgf = 3'd1;
            4'b0101:                            hgf = 3'd2;
            4'b1100, 4'b0011:                   hgf = 3'd3;
            4'b1101, 4'b0010:                   hgf = 3'd4;
            4'b1010:                            hgf = 3'd5;
            4'b0110:                            hgf = 3'd6;
            4'b1110, 4'b0001, 4'b0111, 4'b1000: hgf = 3'd7;
            default:                            miss4 = 1'b1;
        endcase
        // K28.7 only exists in the alternate form
        if (k28 && (four == FOUR_P7_N || four == FOUR_P7_P)) miss4 = 1'b1;
    end

    // K23/27/29/30.7 are the alternate-7 forms following those 6b codes
    always_comb begin
        kx7 = 1'b0;
        case (six)
            6'b111010, 6'b000101, 6'b110110, 6'b001001,
            6'b101110, 6'b010001, 6'b011110, 6'b100001:
                kx7 = (four_raw == FOUR_A7_N) || (four_raw == FOUR_A7_P);
            default: kx7 = 1'b0;
        endcase
        kout = (k28 && !miss4) || kx7;
    end

endmodule

// File: rtl/dec_disparity_check.sv
// 8b/10b symbol decoder with code-group and running-disparity checking.
// One-cycle latency, no backpressure.
// Ports:
//   clk, rst_n - clock, asynchronous active-low reset
//   in_valid   - sym holds a symbol this cycle
//   sym        - received symbol {j,h,g,f,i,e,d,c,b,a}
//   out_valid  - registered outputs below describe one accepted symbol
//   dout       - decoded byte {H,G,F,E,D,C,B,A}
//   kout       - control character
//   code_err   - illegal 6b or 4b code group
//   disp_err   - sub-block polarity conflicts with running disparity
//   rd         - current running disparity (0 = negative)
module dec_disparity_check
    import dec8b10b_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [SYM_W-1:0]  sym,
    output logic              out_valid,
    output logic [BYTE_W-1:0] dout,
    output logic              kout,
    output logic              code_err,
    output logic              disp_err,
    output logic              rd
);

    logic [SIX_W-1:0]  six;
    logic [FOUR_W-1:0] four;
    wclass_e           wc6;
    wclass_e           wc4;
    logic              k28;
    logic [4:0]        lut_edcba;
    logic [2:0]        lut_hgf;
    logic              lut_miss6;
    logic              lut_miss4;
    logic              lut_kout;
    logic              rd6;
    logic              rd4;
    logic              derr6;
    logic              derr4;
    logic              cerr;

    dec_lut u_lut (
        .sym   (sym),
        .k28   (k28),
        .edcba (lut_edcba),
        .hgf   (lut_hgf),
        .miss6 (lut_miss6),
        .miss4 (lut_miss4),
        .kout  (lut_kout)
    );

    // Weight classification, disparity tracking and error detection
    always_comb begin
        six   = abcdei(sym);
        four  = fghj(sym);
        wc6   = class6(six);
        wc4   = class4(four);
        k28   = (six == SIX_K28_N) || (six == SIX_K28_P);
        rd6   = rd;
        derr6 = 1'b0;
        rd4   = rd6;
        derr4 = 1'b0;

        // Weight-illegal sub-blocks leave RD untouched
        if (wc6 != WC_BAD) begin
            if (six == SIX_000111) begin
                rd6   = RD_POS;
                derr6 = (rd == RD_NEG);
            end else if (six == SIX_111000) begin
                rd6   = RD_NEG;
                derr6 = (rd == RD_POS);
            end else if (wc6 == WC_POS) begin
                rd6   = RD_POS;
                derr6 = (rd == RD_POS);
            end else if (wc6 == WC_NEG) begin
                rd6   = RD_NEG;
                derr6 = (rd == RD_NEG);
            end
        end

        rd4 = rd6;
        if (wc4 != WC_BAD) begin
            if (four == FOUR_0011) begin
                rd4   = RD_POS;
                derr4 = (rd6 == RD_NEG);
            end else if (four == FOUR_1100) begin
                rd4   = RD_NEG;
                derr4 = (rd6 == RD_POS);
            end else if (wc4 == WC_POS) begin
                rd4   = RD_POS;
                derr4 = (rd6 == RD_POS);
            end else if (wc4 == WC_NEG) begin
                rd4   = RD_NEG;
                derr4 = (rd6 == RD_NEG);
            end
        end

        cerr = (wc6 == WC_BAD) || (wc4 == WC_BAD) || lut_miss6 || lut_miss4;
    end

    // Output and RD registers; everything holds across idle cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            dout      <= '0;
            kout      <= 1'b0;
            code_err  <= 1'b0;
            disp_err  <= 1'b0;
            rd        <= RD_NEG;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                dout     <= {lut_hgf, lut_edcba};
                kout     <= lut_kout && !cerr;
                code_err <= cerr;
                disp_err <= derr6 || derr4;
                rd       <= rd4;
            end
        end
    end

endmodule

// File: tb/tb_dec_disparity_check.sv
// Directed bench for dec_disparity_check: hand-computed symbols and results.
module tb_dec_disparity_check;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [9:0] sym;
    logic       out_valid;
    logic [7:0] dout;
    logic       kout;
    logic       code_err;
    logic       disp_err;
    logic       rd;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dec_disparity_check dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .sym       (sym),
        .out_valid (out_valid),
        .dout      (dout),
        .kout      (kout),
        .code_err  (code_err),
        .disp_err  (disp_err),
        .rd        (rd)
    );

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
        end
    endtask

    // Full check of one result: valid, byte, K, code error, disparity error, RD
    task automatic chk_all(input string tag, input logic v, input logic [7:0] d,
                           input logic k, input logic ce, input logic de, input logic r);
        chk1({tag, ".out_valid"}, out_valid, v);
        chk8({tag, ".dout"}, dout, d);
        chk1({tag, ".kout"}, kout, k);
        chk1({tag, ".code_err"}, code_err, ce);
        chk1({tag, ".disp_err"}, disp_err, de);
        chk1({tag, ".rd"}, rd, r);
    endtask

    task automatic send(input logic [9:0] s);
        @(negedge clk);
        in_valid = 1'b1;
        sym      = s;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        @(negedge clk);
        rst_n    = 1'b1;
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        sym      = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_all("reset", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // K28.5 RD- then K28.5 RD+
        send(10'h17C);
        chk_all("k285_neg", 1'b1, 8'hBC, 1'b1, 1'b0, 1'b0, 1'b1);
        send(10'h283);
        chk_all("k285_pos", 1'b1, 8'hBC, 1'b1, 1'b0, 1'b0, 1'b0);

        // D.21.5 is neutral: RD unchanged at either polarity
        send(10'h155);
        chk_all("d215_rdn", 1'b1, 8'hB5, 1'b0, 1'b0, 1'b0, 1'b0);
        send(10'h17C);
        chk1("k285_b.rd", rd, 1'b1);
        send(10'h155);
        chk_all("d215_rdp", 1'b1, 8'hB5, 1'b0, 1'b0, 1'b0, 1'b1);

        // Idle gap holds everything but out_valid
        idle();
        chk_all("gap", 1'b0, 8'hB5, 1'b0, 1'b0, 1'b0, 1'b1);

        // All-zero symbol: code error, RD held
        send(10'h000);
        chk1("zero.code_err", code_err, 1'b1);
        chk1("zero.kout", kout, 1'b0);
        chk1("zero.rd", rd, 1'b1);

        // Asynchronous reset mid-stream drops the in-flight symbol
        @(negedge clk);
        in_valid = 1'b1;
        sym      = 10'h17C;
        rst_n    = 1'b0;
        #1;
        chk_all("mid_rst", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        @(posedge clk);
        #1;
        chk_all("post_rst", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);

        // K28.5 RD- repeated: second one violates disparity
        send(10'h17C);
        chk1("k285_1.disp_err", disp_err, 1'b0);
        send(10'h17C);
        chk_all("k285_2", 1'b1, 8'hBC, 1'b1, 1'b0, 1'b1, 1'b1);

        // D.7.0 RD- (111000 1011) then repeated at RD+
        do_reset();
        send(10'h347);
        chk_all("d70_1", 1'b1, 8'h07, 1'b0, 1'b0, 1'b0, 1'b1);
        send(10'h347);
        chk_all("d70_2", 1'b1, 8'h07, 1'b0, 1'b0, 1'b1, 1'b1);

        // Weight-legal 6b 111100 is not in the table
        send(10'h14F);
        chk1("miss6.code_err", code_err, 1'b1);
        chk1("miss6.kout", kout, 1'b0);

        // Bring RD back to negative, then K28.7 (001111 1000)
        send(10'h283);
        chk1("k285_c.rd", rd, 1'b0);
        send(10'h07C);
        chk_all("k287", 1'b1, 8'hFC, 1'b1, 1'b0, 1'b0, 1'b0);

        // K23.7 (111010 1000) vs D23.7 (111010 0001), both at RD-
        send(10'h057);
        chk_all("k237", 1'b1, 8'hF7, 1'b1, 1'b0, 1'b0, 1'b0);
        send(10'h217);
        chk_all("d237", 1'b1, 8'hF7, 1'b0, 1'b0, 1'b0, 1'b0);

        // K28 with primary-7 form is not a legal control character
        send(10'h23C);
        chk1("k28p7.code_err", code_err, 1'b1);
        chk1("k28p7.kout", kout, 1'b0);

        idle();
        chk1("end.out_valid", out_valid, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
